// File: rtl/rmii_tx_arbiter_if.sv
// Request bundle between the frame sources and rmii_tx_arbiter.
// Each of the two sources owns one lane of every vector; source i uses bit i of
// req_valid/req_last/req_ready and byte [8i+7:8i] of req_data.
//   req_valid : source has a byte ready (and therefore a frame pending)
//   req_data  : byte offered by the source
//   req_last  : offered byte is the final byte of the frame
//   req_ready : arbiter accepts the offered byte at the next clock edge
// Modports: master = frame sources, slave = arbiter.
interface rmii_tx_arbiter_if;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/rmii_tx_arbiter.sv
// Two-source round-robin arbiter for a single RMII transmit port.
// Generates preamble/SFD, serialises each granted source's bytes LSB dibit first
// at 2 bits per clock, and holds the line idle for IPG_CYCLES after every frame.
// Ports:
//   clk_50MHz    : RMII reference clock
//   reset_n      : synchronous active-low reset
//   req          : source request bundle (slave side)
//   grant        : one-hot owner of the transmitter, 00 when idle
//   TX_EN/TX0/TX1: registered RMII transmit signals
//   busy         : state machine not idle
//   underrun_err : one-cycle pulse when the granted source is not valid at a ready slot
//   oversize_err : one-cycle pulse when a frame is cut at MAX_BYTES
// IPG_CYCLES must be at least 1.
module rmii_tx_arbiter #(
  parameter int unsigned IPG_CYCLES = 48,
  parameter int unsigned MAX_BYTES  = 1522
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  rmii_tx_arbiter_if.slave req,
  output logic [1:0]       grant,
  output logic             TX_EN,
  output logic             TX0,
  output logic             TX1,
  output logic             busy,
  output logic             underrun_err,
  output logic             oversize_err
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StPreamble = 2'd1;
  localparam logic [1:0] StData     = 2'd2;
  localparam logic [1:0] StIpg      = 2'd3;

  // One counter serves preamble dibits (0..31), byte dibits (0..3) and the IPG.
  localparam int unsigned CntW = (IPG_CYCLES > 32) ? $clog2(IPG_CYCLES) : 5;
  localparam int unsigned BcW  = $clog2(MAX_BYTES + 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BcW-1:0]  bcnt_q, bcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            last_q, last_d;
  logic            rr_q, rr_d;
  logic [1:0]      grant_q, grant_d;
  logic            tx_en_q, tx_en_d;
  logic            tx0_q, tx0_d;
  logic            tx1_q, tx1_d;
  logic            underrun_q, underrun_d;
  logic            oversize_q, oversize_d;

  logic            ready_en;
  logic            end_frame;
  logic            pick;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  // Granted source's lane; only meaningful while a frame is in progress.
  assign sel_valid = req.req_valid[grant_q[1]];
  assign sel_last  = req.req_last[grant_q[1]];
  assign sel_data  = grant_q[1] ? req.req_data[15:8] : req.req_data[7:0];

  // Ready slots: SFD dibit, and the last dibit of every byte not flagged last.
  assign ready_en = ((state_q == StPreamble) && (cnt_q == CntW'(31))) ||
                    ((state_q == StData) && (cnt_q == CntW'(3)) && !last_q);

  assign req.req_ready = ready_en ? grant_q : 2'b00;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    last_d     = last_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    tx_en_d    = tx_en_q;
    tx0_d      = tx0_q;
    tx1_d      = tx1_q;
    underrun_d = 1'b0;
    oversize_d = 1'b0;
    end_frame  = 1'b0;
    pick       = req.req_valid[rr_q] ? rr_q : ~rr_q;

    case (state_q)
      StIdle: begin
        if (|req.req_valid) begin
          grant_d = pick ? 2'b10 : 2'b01;
          rr_d    = ~pick;
          state_d = StPreamble;
          cnt_d   = '0;
          bcnt_d  = '0;
          last_d  = 1'b0;
          tx_en_d = 1'b1;
          tx0_d   = 1'b1;
          tx1_d   = 1'b0;
        end
      end
      StPreamble: begin
        if (!ready_en) begin
          cnt_d = cnt_q + CntW'(1);
          tx0_d = 1'b1;
          tx1_d = (cnt_q == CntW'(30));  // final dibit of SFD 0xD5
        end
      end
      StData: begin
        if (cnt_q == CntW'(3)) begin
          end_frame = last_q;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          shift_d = shift_q >> 2;
          tx0_d   = shift_q[2];
          tx1_d   = shift_q[3];
        end
      end
      StIpg: begin
        if (cnt_q == CntW'(IPG_CYCLES - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (ready_en) begin
      if (sel_valid) begin
        state_d = StData;
        cnt_d   = '0;
        shift_d = sel_data;
        bcnt_d  = bcnt_q + BcW'(1);
        tx0_d   = sel_data[0];
        tx1_d   = sel_data[1];
        last_d  = 1'b0;
        if (sel_last) begin
          last_d = 1'b1;
        end else if (bcnt_q == BcW'(MAX_BYTES - 1)) begin
          last_d     = 1'b1;
          oversize_d = 1'b1;
        end
      end else begin
        // Source starved the line: cut the frame here, no padding or FCS repair.
        end_frame  = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (end_frame) begin
      state_d = StIpg;
      cnt_d   = '0;
      tx_en_d = 1'b0;
      tx0_d   = 1'b0;
      tx1_d   = 1'b0;
      grant_d = 2'b00;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      rr_q       <= 1'b0;
      grant_q    <= 2'b00;
      tx_en_q    <= 1'b0;
      tx0_q      <= 1'b0;
      tx1_q      <= 1'b0;
      underrun_q <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      tx_en_q    <= tx_en_d;
      tx0_q      <= tx0_d;
      tx1_q      <= tx1_d;
      underrun_q <= underrun_d;
      oversize_q <= oversize_d;
    end
  end

  assign grant        = grant_q;
  assign TX_EN        = tx_en_q;
  assign TX0          = tx0_q;
  assign TX1          = tx1_q;
  assign busy         = (state_q != StIdle);
  assign underrun_err = underrun_q;
  assign oversize_err = oversize_q;

endmodule
